// File: rtl/rip_hazard_ctrl.sv
// rip_hazard_ctrl: decode-ready / execute-stall controller for the rip-cpu
// integer pipeline, with load-use, memory-wait and redirect-flush handling.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   if_valid                 fetch presents a valid instruction
//   if_rs1_num, if_rs2_num   source registers of the fetched instruction
//   de_rd_num, de_load       destination / load flag of the DE/EX instruction
//   mem_req, mem_ack         memory handshake from EX
//   pc_redirect              taken branch, jump or trap resolved in EX
//   de_ready                 decode may latch the fetched instruction
//   ex_stall                 hold DE/EX and all later stage registers
//   flush                    fetch discards in-flight instruction(s)
//   mem_err                  one-cycle pulse on memory timeout
//   stall_cnt, bubble_cnt    saturating performance counters
module rip_hazard_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned MEM_TIMEOUT  = 255,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             if_valid,
    input  logic [4:0]       if_rs1_num,
    input  logic [4:0]       if_rs2_num,
    input  logic [4:0]       de_rd_num,
    input  logic             de_load,
    input  logic             mem_req,
    input  logic             mem_ack,
    input  logic             pc_redirect,
    output logic             de_ready,
    output logic             ex_stall,
    output logic             flush,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt
);

    localparam int unsigned FC_W = 3;
    localparam int unsigned WT_W = 16;

    localparam logic [FC_W-1:0] FC_LOAD = FC_W'(FLUSH_CYCLES - 1);
    localparam logic [WT_W-1:0] WT_LAST = WT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_MEM_WAIT,
        ST_FLUSH
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [FC_W-1:0] fcnt_q;
    logic [FC_W-1:0] fcnt_d;
    logic [WT_W-1:0] wcnt_q;
    logic [WT_W-1:0] wcnt_d;
    logic            err_q;
    logic            err_d;

    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] bubble_cnt_q;

    logic lu;
    logic rd_nz;
    logic rs1_hit;
    logic rs2_hit;
    logic mem_miss;

    logic de_ready_c;
    logic ex_stall_c;
    logic flush_c;

    // Load-use hazard: the load in DE/EX writes a register the fetched
    // instruction reads. x0 never creates a dependency.
    assign rd_nz    = (de_rd_num != 5'd0);
    assign rs1_hit  = (de_rd_num == if_rs1_num);
    assign rs2_hit  = (de_rd_num == if_rs2_num);
    assign lu       = de_load & rd_nz & (rs1_hit | rs2_hit);

    // A request acked in the same cycle completes without stalling.
    assign mem_miss = mem_req & ~mem_ack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            fcnt_q  <= '0;
            wcnt_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            wcnt_q  <= wcnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        fcnt_d     = fcnt_q;
        wcnt_d     = wcnt_q;
        err_d      = 1'b0;
        de_ready_c = 1'b0;
        ex_stall_c = 1'b0;
        flush_c    = 1'b0;

        unique case (state_q)
            ST_RUN: begin
                if (pc_redirect) begin
                    flush_c = 1'b1;
                    state_d = ST_FLUSH;
                    fcnt_d  = FC_LOAD;
                end else if (mem_miss) begin
                    ex_stall_c = 1'b1;
                    state_d    = ST_MEM_WAIT;
                    wcnt_d     = '0;
                end else if (!lu) begin
                    de_ready_c = if_valid;
                end
            end

            // EX is frozen here, so a redirect raised meanwhile is held by
            // its source and taken once the stall drops.
            ST_MEM_WAIT: begin
                ex_stall_c = 1'b1;
                if (mem_ack) begin
                    state_d = ST_RUN;
                end else if (wcnt_q == WT_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_RUN;
                end else begin
                    wcnt_d = wcnt_q + WT_W'(1);
                end
            end

            // A redirect restarts the flush window; a missed memory access
            // abandons it and freezes EX just as it would from RUN.
            ST_FLUSH: begin
                flush_c = 1'b1;
                if (pc_redirect) begin
                    fcnt_d = FC_LOAD;
                end else if (mem_miss) begin
                    ex_stall_c = 1'b1;
                    state_d    = ST_MEM_WAIT;
                    wcnt_d     = '0;
                end else if (fcnt_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    fcnt_d = fcnt_q - FC_W'(1);
                end
            end

            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Reset gates the combinational controls so every output reads 0
    // while rst_n is low, whatever the inputs are doing.
    assign de_ready = de_ready_c & rst_n;
    assign ex_stall = ex_stall_c & rst_n;
    assign flush    = flush_c & rst_n;
    assign mem_err  = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (ex_stall && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt_q <= '0;
        end else if (if_valid && !de_ready && (bubble_cnt_q != '1)) begin
            bubble_cnt_q <= bubble_cnt_q + CNT_W'(1);
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;

endmodule
